// File: rtl/mem_req_arbiter_pkg.sv
// Shared types and constants for the memory request arbiter: address/line types,
// access size, the memory pipeline depth and the arbitration side encoding.
package mem_req_arbiter_pkg;

  typedef logic [31:0]  paddr_t;
  typedef logic [127:0] cacheline_t;
  typedef logic [2:0]   access_size_t;

  // log2 of the line size in bytes; instruction fills always fetch a whole line
  localparam access_size_t SIZE_LINE = 3'd4;

  localparam int MEM_PIPE_LATENCY = 10;

  typedef enum logic {
    ARB_DC = 1'b0,
    ARB_IC = 1'b1
  } mem_arb_side_e;

endpackage

// File: rtl/mem_req_arbiter_if.sv
// Bundles the I-cache, D-cache and memory-side signals of the arbiter.
// The master modport is the arbiter itself; slave is the surrounding environment.
interface mem_req_arbiter_if;
  import mem_req_arbiter_pkg::*;

  logic         ic_req_valid_i;
  logic         ic_req_ready_o;
  paddr_t       ic_req_addr_i;
  logic         ic_rsp_valid_o;
  cacheline_t   ic_rsp_data_o;

  logic         dc_req_valid_i;
  logic         dc_req_ready_o;
  logic         dc_req_is_wr_i;
  paddr_t       dc_req_addr_i;
  cacheline_t   dc_req_wdata_i;
  access_size_t dc_req_size_i;
  logic         dc_rsp_valid_o;
  cacheline_t   dc_rsp_data_o;

  logic         mem_rd_req_valid_o;
  logic         mem_wr_req_valid_o;
  logic         mem_req_is_instr_o;
  paddr_t       mem_address_o;
  cacheline_t   mem_wr_data_o;
  access_size_t mem_access_size_o;
  logic         mem_data_valid_i;
  logic         mem_data_is_instr_i;
  cacheline_t   mem_data_i;

  modport master (
    input  ic_req_valid_i, ic_req_addr_i,
    input  dc_req_valid_i, dc_req_is_wr_i, dc_req_addr_i, dc_req_wdata_i, dc_req_size_i,
    input  mem_data_valid_i, mem_data_is_instr_i, mem_data_i,
    output ic_req_ready_o, ic_rsp_valid_o, ic_rsp_data_o,
    output dc_req_ready_o, dc_rsp_valid_o, dc_rsp_data_o,
    output mem_rd_req_valid_o, mem_wr_req_valid_o, mem_req_is_instr_o,
    output mem_address_o, mem_wr_data_o, mem_access_size_o
  );

  modport slave (
    output ic_req_valid_i, ic_req_addr_i,
    output dc_req_valid_i, dc_req_is_wr_i, dc_req_addr_i, dc_req_wdata_i, dc_req_size_i,
    output mem_data_valid_i, mem_data_is_instr_i, mem_data_i,
    input  ic_req_ready_o, ic_rsp_valid_o, ic_rsp_data_o,
    input  dc_req_ready_o, dc_rsp_valid_o, dc_rsp_data_o,
    input  mem_rd_req_valid_o, mem_wr_req_valid_o, mem_req_is_instr_o,
    input  mem_address_o, mem_wr_data_o, mem_access_size_o
  );

endinterface

// File: rtl/mem_arb_credit_ctr.sv
// Per-client outstanding-read counter: saturating up/down with full/empty flags.
// An increment and decrement in the same cycle cancel out.
module mem_arb_credit_ctr #(
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic inc_i,
  input  logic dec_i,
  output logic full_o,
  output logic empty_o
);

  logic [3:0] r_cnt;
  logic       w_do_inc;
  logic       w_do_dec;

  assign full_o   = (r_cnt >= 4'(MAX_OUTSTANDING));
  assign empty_o  = (r_cnt == 4'd0);
  assign w_do_inc = inc_i && !full_o;
  assign w_do_dec = dec_i && !empty_o;

  // NOTE: state updates use <= so every flop samples pre-edge values, independent of block order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt <= 4'd0;
    end else if (w_do_inc && !w_do_dec) begin
      r_cnt <= r_cnt + 4'd1;
    end else if (w_do_dec && !w_do_inc) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

endmodule

// File: rtl/mem_req_arbiter.sv
// Merges I-cache and D-cache requests onto one registered memory request port and
// routes in-order responses back by tag. Define MEM_ARB_PERF_EN for performance counters.
module mem_req_arbiter
  import mem_req_arbiter_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4,
  parameter int DATA_WIDTH      = 128
) (
  input  logic clk_i,
  input  logic rst_i,
  mem_req_arbiter_if.master bus,
  output logic idle_o,
  output logic err_rsp_o
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0] perf_ic_grants_o,
  output logic [31:0] perf_dc_grants_o,
  output logic [31:0] perf_stall_cycles_o
`endif
);

  logic w_ic_full, w_ic_empty, w_dc_full, w_dc_empty;
  logic w_ic_elig, w_dc_elig;
  logic w_grant_ic, w_grant_dc, w_dc_rd_grant;
  logic w_rsp_ic, w_rsp_dc;

  mem_arb_side_e   r_prio;
  logic            r_rd_valid, r_wr_valid, r_is_instr;
  paddr_t          r_addr;
  logic [DATA_WIDTH-1:0] r_wr_data;
  access_size_t    r_size;
  logic            r_ic_rsp_valid, r_dc_rsp_valid, r_err;
  logic [DATA_WIDTH-1:0] r_ic_rsp_data, r_dc_rsp_data;

  assign w_ic_elig = bus.ic_req_valid_i && !w_ic_full;
  assign w_dc_elig = bus.dc_req_valid_i && (bus.dc_req_is_wr_i || !w_dc_full);

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    w_grant_ic = 1'b0;
    w_grant_dc = 1'b0;
    if (!rst_i) begin
      if (w_ic_elig && w_dc_elig) begin
        w_grant_ic = (r_prio == ARB_IC);
        w_grant_dc = (r_prio == ARB_DC);
      end else begin
        w_grant_ic = w_ic_elig;
        w_grant_dc = w_dc_elig;
      end
    end
  end

  assign w_dc_rd_grant      = w_grant_dc && !bus.dc_req_is_wr_i;
  assign bus.ic_req_ready_o = w_grant_ic;
  assign bus.dc_req_ready_o = w_grant_dc;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_prio     <= ARB_DC;
      r_rd_valid <= 1'b0;
      r_wr_valid <= 1'b0;
      r_is_instr <= 1'b0;
      r_addr     <= '0;
      r_wr_data  <= '0;
      r_size     <= '0;
    end else begin
      r_rd_valid <= w_grant_ic || w_dc_rd_grant;
      r_wr_valid <= w_grant_dc && bus.dc_req_is_wr_i;
      if (w_grant_ic) begin
        r_prio     <= ARB_DC;
        r_is_instr <= 1'b1;
        r_addr     <= bus.ic_req_addr_i;
        r_wr_data  <= '0;
        r_size     <= SIZE_LINE;
      end else if (w_grant_dc) begin
        r_prio     <= ARB_IC;
        r_is_instr <= 1'b0;
        r_addr     <= bus.dc_req_addr_i;
        r_wr_data  <= bus.dc_req_is_wr_i ? bus.dc_req_wdata_i : '0;
        r_size     <= bus.dc_req_size_i;
      end
    end
  end

  assign bus.mem_rd_req_valid_o = r_rd_valid;
  assign bus.mem_wr_req_valid_o = r_wr_valid;
  assign bus.mem_req_is_instr_o = r_is_instr;
  assign bus.mem_address_o      = r_addr;
  assign bus.mem_wr_data_o      = r_wr_data;
  assign bus.mem_access_size_o  = r_size;

  assign w_rsp_ic = bus.mem_data_valid_i && bus.mem_data_is_instr_i;
  assign w_rsp_dc = bus.mem_data_valid_i && !bus.mem_data_is_instr_i;

  mem_arb_credit_ctr #(.MAX_OUTSTANDING(MAX_OUTSTANDING)) u_ic_ctr (
    .clk_i(clk_i), .rst_i(rst_i), .inc_i(w_grant_ic), .dec_i(w_rsp_ic),
    .full_o(w_ic_full), .empty_o(w_ic_empty)
  );

  mem_arb_credit_ctr #(.MAX_OUTSTANDING(MAX_OUTSTANDING)) u_dc_ctr (
    .clk_i(clk_i), .rst_i(rst_i), .inc_i(w_dc_rd_grant), .dec_i(w_rsp_dc),
    .full_o(w_dc_full), .empty_o(w_dc_empty)
  );

  // A response for a client with nothing outstanding is dropped and flagged
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ic_rsp_valid <= 1'b0;
      r_dc_rsp_valid <= 1'b0;
      r_ic_rsp_data  <= '0;
      r_dc_rsp_data  <= '0;
      r_err          <= 1'b0;
    end else begin
      r_ic_rsp_valid <= w_rsp_ic && !w_ic_empty;
      r_dc_rsp_valid <= w_rsp_dc && !w_dc_empty;
      if (w_rsp_ic && !w_ic_empty) r_ic_rsp_data <= bus.mem_data_i;
      if (w_rsp_dc && !w_dc_empty) r_dc_rsp_data <= bus.mem_data_i;
      if ((w_rsp_ic && w_ic_empty) || (w_rsp_dc && w_dc_empty)) r_err <= 1'b1;
    end
  end

  assign bus.ic_rsp_valid_o = r_ic_rsp_valid;
  assign bus.ic_rsp_data_o  = r_ic_rsp_data;
  assign bus.dc_rsp_valid_o = r_dc_rsp_valid;
  assign bus.dc_rsp_data_o  = r_dc_rsp_data;
  assign err_rsp_o          = r_err;
  assign idle_o             = w_ic_empty && w_dc_empty && !r_rd_valid && !r_wr_valid;

`ifdef MEM_ARB_PERF_EN
  logic        w_stall;
  logic [31:0] r_perf_ic, r_perf_dc, r_perf_stall;

  assign w_stall = (bus.ic_req_valid_i && !w_grant_ic) || (bus.dc_req_valid_i && !w_grant_dc);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_perf_ic    <= '0;
      r_perf_dc    <= '0;
      r_perf_stall <= '0;
    end else begin
      if (w_grant_ic && (r_perf_ic != '1))  r_perf_ic    <= r_perf_ic + 32'd1;
      if (w_grant_dc && (r_perf_dc != '1))  r_perf_dc    <= r_perf_dc + 32'd1;
      if (w_stall && (r_perf_stall != '1))  r_perf_stall <= r_perf_stall + 32'd1;
    end
  end

  assign perf_ic_grants_o    = r_perf_ic;
  assign perf_dc_grants_o    = r_perf_dc;
  assign perf_stall_cycles_o = r_perf_stall;
`endif

endmodule
